// File: rtl/instr_mem_pkg.sv
// Shared types and helpers for the instruction memory.
// Holds the fetch FSM state encoding, the all-zero instruction constant
// and the counter-width helper used to size the latency counter.
package instr_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } state_t;

  // Wide enough for any practical WORD_W; users slice [WORD_W-1:0].
  localparam int unsigned MAX_WORD_W = 1024;
  localparam logic [MAX_WORD_W-1:0] ZERO_INSTR = '0;

  // Bits needed to hold 0..value-1, never less than one so LATENCY=1
  // still gets a real (always-zero) counter register.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/instr_mem_array.sv
// Instruction storage: DEPTH x WORD_W words.
// Latency: write lands on the clock edge, read is combinational.
// Backpressure: none; no reset so contents survive a block reset.
module instr_mem_array #(
  parameter int DEPTH  = 256,
  parameter int WORD_W = 32,
  parameter int IDX_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [WORD_W-1:0] i_wr_dat,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic [WORD_W-1:0] o_rd_dat
);

  logic [WORD_W-1:0] r_mem [DEPTH];

  // Program-load write port; storage is deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_idx] <= i_wr_dat;
  end

  assign o_rd_dat = r_mem[i_rd_idx];

endmodule

// File: rtl/instr_memory.sv
// Fixed-latency instruction fetch memory with a program-load write port.
// Latency: VALID rises exactly LATENCY edges after a READ is accepted.
// Backpressure: BUSYWAIT stalls the CPU; writes arriving while busy are dropped and flagged.
module instr_memory
  import instr_mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int WORD_W  = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] PC,
  input  logic              READ,
  input  logic              WR_EN,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [WORD_W-1:0] WR_DATA,
  output logic [WORD_W-1:0] INSTRUCTION,
  output logic              BUSYWAIT,
  output logic              VALID,
  output logic              ERR,
  output logic              WR_DROP
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = clog2(LATENCY);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("instr_memory: LATENCY must be in 1..15");
  end
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("instr_memory: DEPTH must be a power of two, at least 4");
  end
  if (ADDR_W < IDX_W + 2) begin : g_bad_addr
    $error("instr_memory: ADDR_W too narrow for DEPTH");
  end

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0]  r_pc, w_pc_nxt;
  logic [WORD_W-1:0]  r_instr, w_instr_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_vld, w_vld_nxt;
  logic               r_err, w_err_nxt;
  logic               r_wr_drop, w_wr_drop_nxt;

  logic [ADDR_W-1:0]  w_rd_word, w_wr_word;
  logic               w_rd_bad, w_wr_ok;
  logic [WORD_W-1:0]  w_rd_dat;

  // Word indices are the byte address without its two low bits.
  assign w_rd_word = r_pc >> 2;
  assign w_wr_word = WR_ADDR >> 2;
  assign w_rd_bad  = (r_pc[1:0] != 2'b00) || (w_rd_word >= ADDR_W'(DEPTH));
  assign w_wr_ok   = WR_EN && (r_state == IDLE) && (WR_ADDR[1:0] == 2'b00)
                     && (w_wr_word < ADDR_W'(DEPTH));

  instr_mem_array #(
    .DEPTH  (DEPTH),
    .WORD_W (WORD_W),
    .IDX_W  (IDX_W)
  ) u_array (
    .i_clk    (CLK),
    .i_wr_en  (w_wr_ok),
    .i_wr_idx (WR_ADDR[IDX_W+1:2]),
    .i_wr_dat (WR_DATA),
    .i_rd_idx (r_pc[IDX_W+1:2]),
    .o_rd_dat (w_rd_dat)
  );

  // Next-state and next-output logic for the fetch FSM.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pc_nxt      = r_pc;
    w_instr_nxt   = r_instr;
    w_busy_nxt    = r_busy;
    w_vld_nxt     = 1'b0;
    w_err_nxt     = 1'b0;
    w_wr_drop_nxt = WR_EN && (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (READ) begin
          w_state_nxt = WAIT;
          w_pc_nxt    = PC;
          w_cnt_nxt   = CNT_W'(LATENCY - 1);
          w_busy_nxt  = 1'b1;
        end
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = RESPOND;
          w_vld_nxt   = 1'b1;
          w_busy_nxt  = 1'b0;
          w_err_nxt   = w_rd_bad;
          w_instr_nxt = w_rd_bad ? ZERO_INSTR[WORD_W-1:0] : w_rd_dat;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      RESPOND: begin
        if (READ) begin
          w_state_nxt = WAIT;
          w_pc_nxt    = PC;
          w_cnt_nxt   = CNT_W'(LATENCY - 1);
          w_busy_nxt  = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State, counter and registered outputs; reset discards any in-flight fetch.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_pc      <= '0;
      r_instr   <= ZERO_INSTR[WORD_W-1:0];
      r_busy    <= 1'b0;
      r_vld     <= 1'b0;
      r_err     <= 1'b0;
      r_wr_drop <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pc      <= w_pc_nxt;
      r_instr   <= w_instr_nxt;
      r_busy    <= w_busy_nxt;
      r_vld     <= w_vld_nxt;
      r_err     <= w_err_nxt;
      r_wr_drop <= w_wr_drop_nxt;
    end
  end

  assign INSTRUCTION = r_instr;
  assign BUSYWAIT    = r_busy;
  assign VALID       = r_vld;
  assign ERR         = r_err;
  assign WR_DROP     = r_wr_drop;

endmodule

// File: tb/tb_instr_memory.sv
// Self-checking bench: three instances (LATENCY 1, 2, 5) share one stimulus.
// A word-array model plus fetch timing rules gives every expected value.
// Directed cases first, then a randomized mix of loads and fetches.
module tb_instr_memory;

  localparam int ADDR_W = 32;
  localparam int WORD_W = 32;
  localparam int DEPTH  = 16;
  localparam int NI     = 3;
  localparam int LMAX   = 5;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic              READ = 1'b0;
  logic              WR_EN = 1'b0;
  logic [ADDR_W-1:0] PC = '0;
  logic [ADDR_W-1:0] WR_ADDR = '0;
  logic [WORD_W-1:0] WR_DATA = '0;

  logic [NI-1:0]     vld, busy, err, drop;
  logic [WORD_W-1:0] instr [NI];

  logic [WORD_W-1:0] mdl_mem [DEPTH];
  int n_chk = 0;
  int n_err = 0;

  initial forever #5 CLK = ~CLK;

  instr_memory #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .DEPTH(DEPTH), .LATENCY(1)) u_l1 (
    .CLK(CLK), .RESET(RESET), .PC(PC), .READ(READ), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR),
    .WR_DATA(WR_DATA), .INSTRUCTION(instr[0]), .BUSYWAIT(busy[0]), .VALID(vld[0]),
    .ERR(err[0]), .WR_DROP(drop[0]));
  instr_memory #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .DEPTH(DEPTH), .LATENCY(2)) u_l2 (
    .CLK(CLK), .RESET(RESET), .PC(PC), .READ(READ), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR),
    .WR_DATA(WR_DATA), .INSTRUCTION(instr[1]), .BUSYWAIT(busy[1]), .VALID(vld[1]),
    .ERR(err[1]), .WR_DROP(drop[1]));
  instr_memory #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .DEPTH(DEPTH), .LATENCY(5)) u_l5 (
    .CLK(CLK), .RESET(RESET), .PC(PC), .READ(READ), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR),
    .WR_DATA(WR_DATA), .INSTRUCTION(instr[2]), .BUSYWAIT(busy[2]), .VALID(vld[2]),
    .ERR(err[2]), .WR_DROP(drop[2]));

  function automatic int lat_of(input int i);
    case (i)
      0:       return 1;
      1:       return 2;
      default: return 5;
    endcase
  endfunction

  function automatic bit is_bad(input logic [ADDR_W-1:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= ADDR_W'(DEPTH));
  endfunction

  task automatic check(input string tag, input logic [WORD_W-1:0] got,
                       input logic [WORD_W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Load one word while every instance is idle; the model follows the drop rules.
  task automatic write_word(input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] d);
    WR_EN = 1'b1; WR_ADDR = a; WR_DATA = d;
    tick();
    WR_EN = 1'b0;
    if (!is_bad(a)) mdl_mem[int'(a >> 2)] = d;
    for (int i = 0; i < NI; i++)
      check($sformatf("wr_drop_idle L%0d", lat_of(i)), WORD_W'(drop[i]), '0);
  endtask

  // One fetch: VALID expected exactly L edges after acceptance, BUSYWAIT before it.
  task automatic fetch(input logic [ADDR_W-1:0] a, input bit scramble, input bit with_wr,
                       input logic [WORD_W-1:0] wd, input bit drop_wr);
    logic [WORD_W-1:0] exp_w;
    bit                exp_e;
    int                L;
    READ = 1'b1; PC = a;
    if (with_wr) begin
      WR_EN = 1'b1; WR_ADDR = a; WR_DATA = wd;
    end
    tick();
    READ = 1'b0; WR_EN = 1'b0;
    if (with_wr && !is_bad(a)) mdl_mem[int'(a >> 2)] = wd;
    exp_e = is_bad(a);
    exp_w = exp_e ? '0 : mdl_mem[int'(a >> 2)];
    for (int i = 0; i < NI; i++)
      check($sformatf("busy_accept L%0d", lat_of(i)), WORD_W'(busy[i]), 1);
    if (drop_wr) begin
      WR_EN = 1'b1; WR_ADDR = 32'h4; WR_DATA = $urandom;
    end
    for (int k = 1; k <= LMAX + 1; k++) begin
      if (scramble) PC = $urandom;
      tick();
      WR_EN = 1'b0;
      for (int i = 0; i < NI; i++) begin
        L = lat_of(i);
        check($sformatf("valid L%0d k%0d", L, k), WORD_W'(vld[i]), WORD_W'(k == L));
        check($sformatf("busy L%0d k%0d", L, k), WORD_W'(busy[i]), WORD_W'(k < L));
        check($sformatf("wr_drop L%0d k%0d", L, k), WORD_W'(drop[i]),
              WORD_W'(drop_wr && k == 1));
        if (k >= L) check($sformatf("instr pc=%h L%0d k%0d", a, L, k), instr[i], exp_w);
        if (k == L) check($sformatf("err pc=%h L%0d", a, L), WORD_W'(err[i]), WORD_W'(exp_e));
      end
    end
  endtask

  initial begin
    logic [ADDR_W-1:0] a;
    int                r, L;
    bit                exp_v;

    // Reset state
    #2 RESET = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      check("rst_valid", WORD_W'(vld[i]), '0);
      check("rst_busy", WORD_W'(busy[i]), '0);
      check("rst_instr", instr[i], '0);
    end
    tick();
    RESET = 1'b1;

    // Preload everything so the model never holds unknown words.
    for (int w = 0; w < DEPTH; w++) write_word(ADDR_W'(w * 4), $urandom);
    write_word(32'h0, 32'h00040005);
    write_word(32'h4, 32'h00020009);
    write_word(32'h8, 32'h02060402);

    fetch(32'h0, 0, 0, '0, 0);
    fetch(32'h4, 0, 0, '0, 0);
    fetch(32'h8, 0, 0, '0, 0);

    // READ held high: one fetch per L+1 cycles, BUSYWAIT low only with VALID.
    READ = 1'b1; PC = 32'h0;
    for (int t = 1; t <= 24; t++) begin
      tick();
      for (int i = 0; i < NI; i++) begin
        L = lat_of(i);
        exp_v = (t >= L + 1) && (((t - 1 - L) % (L + 1)) == 0);
        check($sformatf("stream_valid L%0d t%0d", L, t), WORD_W'(vld[i]), WORD_W'(exp_v));
        check($sformatf("stream_busy L%0d t%0d", L, t), WORD_W'(busy[i]), WORD_W'(!exp_v));
        if (exp_v) check($sformatf("stream_instr L%0d", L), instr[i], mdl_mem[0]);
      end
    end
    READ = 1'b0;
    repeat (LMAX + 2) tick();

    // Misaligned and out-of-range fetches
    fetch(32'h2, 0, 0, '0, 0);
    fetch(ADDR_W'(DEPTH * 4), 0, 0, '0, 0);

    // Write during WAIT is dropped; word 4 keeps its old contents.
    fetch(32'h0, 0, 0, '0, 1);
    fetch(32'h4, 0, 0, '0, 0);
    write_word(32'h5, 32'hdeadbeef);
    fetch(32'h4, 0, 0, '0, 0);

    // Reset one edge into WAIT discards the fetch; the array is retained.
    READ = 1'b1; PC = 32'h8;
    tick();
    READ = 1'b0;
    #2 RESET = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      check("midrst_valid", WORD_W'(vld[i]), '0);
      check("midrst_busy", WORD_W'(busy[i]), '0);
      check("midrst_err", WORD_W'(err[i]), '0);
      check("midrst_instr", instr[i], '0);
    end
    repeat (LMAX + 1) begin
      tick();
      for (int i = 0; i < NI; i++) check("midrst_no_valid", WORD_W'(vld[i]), '0);
    end
    RESET = 1'b1;
    fetch(32'h0, 0, 0, '0, 0);

    // Simultaneous load and fetch of the same word returns the new word.
    fetch(32'hc, 0, 1, 32'h13572468, 0);
    // PC wandering during WAIT must not change the returned word.
    fetch(32'h8, 1, 0, '0, 0);

    // Randomized mix
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 3);
      a = ADDR_W'($urandom_range(0, DEPTH * 4 + 7));
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      if (r == 0) write_word(a, $urandom);
      else fetch(a, bit'($urandom_range(0, 1)), r == 3, $urandom, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_memory.md
INSTR_MEMORY -- requirements
Module: instr_memory

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning PC width in bits.
REQ-002 The block SHALL have parameter WORD_W, default 32, meaning instruction width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 256, meaning number of instruction words stored (power of two, at least 4).
REQ-004 The block SHALL have parameter LATENCY, default 2, meaning clock cycles from request acceptance to data return (1 to 15).
REQ-005 The block SHALL have one clock; reset is asynchronous and active-low, with ports CLK and RESET.
REQ-006 The block SHALL have the following ports, one per line: name, direction, width, meaning:
- CLK  in  1  rising-edge clock
- RESET  in  1  asynchronous active-low reset
- PC  in  ADDR_W  byte address of the requested instruction
- READ  in  1  fetch request
- WR_EN  in  1  program-load write strobe
- WR_ADDR  in  ADDR_W  byte address for the load
- WR_DATA  in  WORD_W  instruction word to load
- INSTRUCTION  out  WORD_W  fetched word
- BUSYWAIT  out  1  fetch in progress; CPU stalls the PC
- VALID  out  1  one-cycle pulse: INSTRUCTION is valid
- ERR  out  1  qualifies VALID: misaligned or out-of-range fetch
- WR_DROP  out  1  one-cycle pulse: write rejected

Function
REQ-007 The FSM SHALL have states IDLE, WAIT and RESPOND; all outputs SHALL be registered.
REQ-008 In IDLE, or in RESPOND with READ=1 on a rising edge: latch PC, load the counter with LATENCY-1, set BUSYWAIT=1 and go to WAIT.
REQ-009 WAIT SHALL decrement the counter each edge; at counter 0 the next edge SHALL go to RESPOND, driving VALID=1, BUSYWAIT=0 and INSTRUCTION=data; VALID therefore rises exactly LATENCY edges after acceptance.
REQ-010 RESPOND with READ=0 SHALL return to IDLE; VALID SHALL be high for exactly one cycle.
REQ-011 INSTRUCTION SHALL hold its last value until the next VALID.
REQ-012 PC changes while BUSYWAIT=1 SHALL be ignored; the latched address is used.
REQ-013 Word index = latched PC[ADDR_W-1:2]; PC[1:0]!=0 or index>=DEPTH SHALL return INSTRUCTION=0 with ERR=1 at VALID, at the same latency.
REQ-014 WR_EN in IDLE SHALL write WR_DATA at WR_ADDR[ADDR_W-1:2] on the edge; out-of-range or misaligned writes SHALL be dropped.
REQ-015 WR_EN while BUSYWAIT=1 or in RESPOND SHALL be dropped with WR_DROP pulsed next cycle; memory SHALL be unchanged.
REQ-016 When WR_EN and READ are both high in IDLE, the write SHALL happen, and the read SHALL be accepted and return the newly written word if addresses match.

Reset
REQ-017 RESET=0 SHALL immediately force IDLE, INSTRUCTION=0, BUSYWAIT=0, VALID=0, ERR=0, WR_DROP=0 and counter=0, including mid-fetch (the in-flight fetch is discarded, no VALID).
REQ-018 Reset SHALL NOT clear the storage array; contents persist across reset.
REQ-019 After RESET rises, the first READ SHALL be accepted on the next rising edge.

Structure
REQ-020 Package instr_mem_pkg SHALL hold the FSM state typedef, the ZERO_INSTR constant and the counter-width function clog2(LATENCY).
REQ-021 Storage SHALL be a sub-module instr_mem_array (DEPTH x WORD_W, synchronous write, asynchronous read); FSM and counter SHALL live in instr_memory.
REQ-022 Parameter checks (LATENCY 1..15, DEPTH power of two) SHALL be elaboration-time errors.

Verification
REQ-023 Load 0x00040005 @0, 0x00020009 @4, 0x02060402 @8; READ PC=0,4,8 with LATENCY=2 -> each VALID two edges after acceptance with those words, ERR=0.
REQ-024 READ held high continuously from PC=0 -> one fetch per LATENCY+1 cycles; BUSYWAIT low only in RESPOND cycles.
REQ-025 PC=0x2 -> VALID, ERR=1, INSTRUCTION=0; PC=DEPTH*4 -> VALID, ERR=1, INSTRUCTION=0.
REQ-026 WR_EN during WAIT to address 4 -> WR_DROP pulse; a later read of 4 returns the old 0x00020009.
REQ-027 RESET low one edge into WAIT -> no VALID, outputs zero; after release, READ PC=0 returns 0x00040005 (array retained).
REQ-028 LATENCY=1 and LATENCY=5 builds -> VALID at exactly 1 and 5 edges after acceptance; a PC change during WAIT does not alter the returned word.
